// File: rtl/pipe_skid_reg.sv
// Pipeline register with a main (head) entry and an optional skid entry.
// Define PIPE_SKID_REG_SKID_EN to get the two-deep registered-ready version.
module pipe_skid_reg #(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [1:0]       occ_q;
    logic             accept;
    logic             consume;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_valid ? main_q : NOP_VALUE;
    assign consume   = out_valid & out_ready;
    assign accept    = in_valid & in_ready;
    assign occupancy = occ_q;

`ifdef PIPE_SKID_REG_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;

    // Ready comes from a flop so out_ready never reaches in_ready combinationally.
    assign in_ready = in_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= NOP_VALUE;
            skid_q     <= NOP_VALUE;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_TWO);
            occ_q      <= (state_d == ST_TWO) ? 2'd2 :
                          (state_d == ST_ONE) ? 2'd1 : 2'd0;
        end
    end
`else
    // Single entry: the slot frees in the same cycle the head is consumed.
    assign in_ready = ~out_valid | out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept) begin
                        main_d = in_data;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
            occ_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            occ_q   <= (state_d == ST_ONE) ? 2'd1 : 2'd0;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg; follows PIPE_SKID_REG_SKID_EN like the RTL.
module tb_pipe_skid_reg;

    localparam int unsigned W   = 16;
    localparam logic [W-1:0] NOP = 16'hDEAD;
`ifdef PIPE_SKID_REG_SKID_EN
    localparam int MAXOCC = 2;
`else
    localparam int MAXOCC = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d);
        in_valid = v;
        in_data  = d;
    endtask

    // Monitor: every consume must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got 0x%0h expected no entry", out_data);
                end else begin
                    chk("out_order", out_data, exp_q.pop_front());
                end
            end else if (!out_valid) begin
                chk("bubble_nop", out_data, NOP);
            end
        end
    end

    initial begin
        int m_occ;
        logic iv, ordy, pred_ready;
        logic [W-1:0] d;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0);
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, NOP);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occ", occupancy, 0);
        rst = 1'b0;

        // Streaming at full rate
        out_ready = 1'b1;
        exp_q.push_back(16'h1); exp_q.push_back(16'h2); exp_q.push_back(16'h3);
        drive(1'b1, 16'h1); step();
        chk("s1_valid", out_valid, 1); chk("s1_data", out_data, 16'h1); chk("s1_occ", occupancy, 1);
        drive(1'b1, 16'h2); step();
        chk("s2_data", out_data, 16'h2); chk("s2_occ", occupancy, 1);
        drive(1'b1, 16'h3); step();
        chk("s3_data", out_data, 16'h3); chk("s3_occ", occupancy, 1);
        drive(1'b0, '0); step();
        chk("s_drained", out_valid, 0); chk("s_drained_occ", occupancy, 0);

`ifdef PIPE_SKID_REG_SKID_EN
        // Backpressure fills the skid; 0xC waits for room
        out_ready = 1'b0;
        exp_q.push_back(16'hA); exp_q.push_back(16'hB); exp_q.push_back(16'hC);
        drive(1'b1, 16'hA); step();
        chk("bp_occ1", occupancy, 1); chk("bp_rdy1", in_ready, 1);
        drive(1'b1, 16'hB); step();
        chk("bp_occ2", occupancy, 2); chk("bp_rdy2", in_ready, 0);
        drive(1'b1, 16'hC); step();
        chk("bp_hold_occ", occupancy, 2); chk("bp_hold_data", out_data, 16'hA);
        chk("bp_hold_rdy", in_ready, 0);
        out_ready = 1'b1; step();
        chk("bp_rel_data", out_data, 16'hB); chk("bp_rel_occ", occupancy, 1);
        chk("bp_rel_rdy", in_ready, 1);
        step();
        chk("bp_c_data", out_data, 16'hC); chk("bp_c_occ", occupancy, 1);
        drive(1'b0, '0); step();
        chk("bp_empty", out_valid, 0);
`else
        // Stalled head frees the input the same cycle out_ready rises
        out_ready = 1'b0;
        exp_q.push_back(16'hA); exp_q.push_back(16'hB);
        drive(1'b1, 16'hA); step();
        chk("nb_occ1", occupancy, 1); chk("nb_rdy_stall", in_ready, 0);
        drive(1'b1, 16'hB); step();
        chk("nb_hold_data", out_data, 16'hA); chk("nb_hold_occ", occupancy, 1);
        out_ready = 1'b1; #1;
        chk("nb_rdy_comb", in_ready, 1);
        step();
        chk("nb_b_data", out_data, 16'hB); chk("nb_b_occ", occupancy, 1);
        drive(1'b0, '0); step();
        chk("nb_empty", out_valid, 0);
`endif

        // Flush while full discards held entries and the same-cycle offer
        out_ready = 1'b0;
        drive(1'b1, 16'h10); step();
        drive(1'b1, 16'h11); step();
        chk("fl_full_occ", occupancy, MAXOCC); chk("fl_full_rdy", in_ready, 0);
        drive(1'b1, 16'hD); flush = 1'b1; step();
        chk("fl_valid", out_valid, 0); chk("fl_data", out_data, NOP);
        chk("fl_occ", occupancy, 0); chk("fl_rdy", in_ready, 1);
        flush = 1'b0; drive(1'b0, '0); step();
        chk("fl_stay_empty", out_valid, 0);

        // Reset dominates a simultaneous flush and offer
        drive(1'b1, 16'h20); step();
        drive(1'b1, 16'h21); step();
        chk("rf_full_occ", occupancy, MAXOCC);
        rst = 1'b1; flush = 1'b1; drive(1'b1, 16'h22); step();
        chk("rf_valid", out_valid, 0); chk("rf_data", out_data, NOP);
        chk("rf_rdy", in_ready, 1); chk("rf_occ", occupancy, 0);
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        exp_q.push_back(16'h5);
        drive(1'b1, 16'h5); step();
        chk("rf_first_valid", out_valid, 1); chk("rf_first_data", out_data, 16'h5);
        drive(1'b0, '0); step();

        // Random handshakes against an occupancy/ready model
        m_occ = 0;
        for (int i = 0; i < 2000; i++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            d    = W'($urandom);
            drive(iv, d);
            out_ready = ordy;
            #1;
`ifdef PIPE_SKID_REG_SKID_EN
            pred_ready = (m_occ < 2);
`else
            pred_ready = (m_occ == 0) || ordy;
`endif
            chk("rnd_in_ready", in_ready, pred_ready);
            if (iv && pred_ready) exp_q.push_back(d);
            m_occ = m_occ + ((iv && pred_ready) ? 1 : 0) - ((m_occ > 0 && ordy) ? 1 : 0);
            step();
            chk("rnd_occ", occupancy, m_occ);
        end

        drive(1'b0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_occ", occupancy, 0);
        chk("drain_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
